imem_port_arbiter: RTL and testbench

Shares the single-port instruction memory between the CPU fetch unit and the program loader/debug port. Grants one requester per cycle and drives the memory enable, write enable, address and data. Returns read data to the requester that issued it through a 2-cycle pipeline. Fetch has priority by default; a starvation counter and a lock input guarantee the loader makes progress.

---
 rtl/imem_port_arbiter_if.sv | 36 +++
 rtl/imem_port_arbiter.sv | 69 ++++++
 tb/tb_imem_port_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch, loader and memory signals of the instruction-memory arbiter
interface imem_port_arbiter_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16
);
   logic              if_req;
   logic [15:0]       if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              ld_req;
   logic              ld_we;
   logic [15:0]       ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_lock;
   logic              ld_gnt;
   logic              ld_rvalid;
   logic [DATA_W-1:0] ld_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_lock, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_lock, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one instruction-memory port between fetch and loader
module imem_port_arbiter #(
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 4
) (
   input logic               clk,
   input logic               rst,
   imem_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD} own_e;

   logic [CW-1:0]     starve_q, starve_d;
   own_e              tag_q, tag_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              ld_rvalid_q, ld_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
   logic              if_gnt, ld_gnt, starved;

   // grant selection and memory drive; the loader wins under lock, starvation or no fetch
   always_comb begin
      starved       = starve_q == CW'(MAX_WAIT);
      ld_gnt        = bus.ld_req & (bus.ld_lock | starved | ~bus.if_req);
      if_gnt        = bus.if_req & ~bus.ld_lock & ~ld_gnt;
      bus.if_gnt    = if_gnt;
      bus.ld_gnt    = ld_gnt;
      bus.mem_en    = if_gnt | ld_gnt;
      bus.mem_we    = ld_gnt & bus.ld_we;
      bus.mem_addr  = if_gnt ? bus.if_addr[ADDR_W-1:0] : ld_gnt ? bus.ld_addr[ADDR_W-1:0] : '0;
      bus.mem_wdata = (if_gnt | ld_gnt) ? bus.ld_wdata : '0;
   end

   // next state: starvation count, read-owner tag and returned data capture
   always_comb begin
      starve_d    = (bus.ld_req & ~ld_gnt) ? (starved ? starve_q : starve_q + 1'b1) : '0;
      tag_d       = if_gnt ? OWN_IF : (ld_gnt & ~bus.ld_we) ? OWN_LD : OWN_NONE;
      if_rvalid_d = tag_q == OWN_IF;
      ld_rvalid_d = tag_q == OWN_LD;
      if_rdata_d  = if_rvalid_d ? bus.mem_rdata : if_rdata_q;
      ld_rdata_d  = ld_rvalid_d ? bus.mem_rdata : ld_rdata_q;
   end

   // state registers; reset drops any read still in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q    <= '0;
         tag_q       <= OWN_NONE;
         if_rvalid_q <= 1'b0;
         ld_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ld_rdata_q  <= '0;
      end else begin
         starve_q    <= starve_d;
         tag_q       <= tag_d;
         if_rvalid_q <= if_rvalid_d;
         ld_rvalid_q <= ld_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         ld_rdata_q  <= ld_rdata_d;
      end
   end

   assign bus.if_rvalid = if_rvalid_q;
   assign bus.ld_rvalid = ld_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.ld_rdata  = ld_rdata_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: scoreboard bench for the instruction-memory arbiter
module tb_imem_port_arbiter;
   localparam int AW = 14;
   localparam int DW = 16;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   errors = 0;
   exp_t if_q[$];
   exp_t ld_q[$];
   exp_t ei, el;
   logic [15:0] ref_mem [0:16383];
   logic [15:0] mem [0:16383];
   logic [15:0] last_if;

   imem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] init_val(input logic [13:0] a);
      return 16'hA000 ^ (16'(a) * 16'd3);
   endfunction

   // memory: requests sampled mid-cycle, applied at the closing edge
   initial begin : memory_model
      logic           p_en, p_we;
      logic [AW-1:0]  p_addr;
      logic [15:0]    p_wdata;
      for (int i = 0; i < 16384; i++) mem[i] = init_val(14'(i));
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         p_en = bus.mem_en;
         p_we = bus.mem_we;
         p_addr = bus.mem_addr;
         p_wdata = bus.mem_wdata;
         @(posedge clk);
         if (p_en && p_we) mem[p_addr] = p_wdata;
         else if (p_en) bus.mem_rdata <= mem[p_addr];
      end
   end

   // scoreboard: every rvalid pops its owner's queue and must land exactly two cycles after grant
   always @(negedge clk) begin
      if (bus.if_rvalid) begin
         vectors++;
         if (if_q.size() == 0) begin
            errors++;
            $display("FAIL if_return unexpected at cyc %0d data %h", cyc, bus.if_rdata);
         end else begin
            ei = if_q.pop_front();
            if (bus.if_rdata !== ei.data || cyc != ei.cyc + 2) begin
               errors++;
               $display("FAIL if_return got %h at cyc %0d, exp %h at cyc %0d", bus.if_rdata, cyc, ei.data, ei.cyc + 2);
            end
         end
      end else if (if_q.size() != 0 && cyc > if_q[0].cyc + 2) begin
         vectors++;
         errors++;
         ei = if_q.pop_front();
         $display("FAIL if_return missing, exp %h at cyc %0d", ei.data, ei.cyc + 2);
      end
      if (bus.ld_rvalid) begin
         vectors++;
         if (ld_q.size() == 0) begin
            errors++;
            $display("FAIL ld_return unexpected at cyc %0d data %h", cyc, bus.ld_rdata);
         end else begin
            el = ld_q.pop_front();
            if (bus.ld_rdata !== el.data || cyc != el.cyc + 2) begin
               errors++;
               $display("FAIL ld_return got %h at cyc %0d, exp %h at cyc %0d", bus.ld_rdata, cyc, el.data, el.cyc + 2);
            end
         end
      end else if (ld_q.size() != 0 && cyc > ld_q[0].cyc + 2) begin
         vectors++;
         errors++;
         el = ld_q.pop_front();
         $display("FAIL ld_return missing, exp %h at cyc %0d", el.data, el.cyc + 2);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.if_req = 1'b0;
      bus.if_addr = '0;
      bus.ld_req = 1'b0;
      bus.ld_we = 1'b0;
      bus.ld_addr = '0;
      bus.ld_wdata = '0;
      bus.ld_lock = 1'b0;
   endtask

   task automatic push_if(input logic [15:0] d);
      exp_t e;
      e.cyc = cyc;
      e.data = d;
      if_q.push_back(e);
      last_if = d;
   endtask

   task automatic push_ld(input logic [15:0] d);
      exp_t e;
      e.cyc = cyc;
      e.data = d;
      ld_q.push_back(e);
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      #3;
      vectors++;
      if ({bus.if_rvalid, bus.ld_rvalid} !== 2'b00) begin
         errors++;
         $display("FAIL reset_rvalid got %b exp 00", {bus.if_rvalid, bus.ld_rvalid});
      end
      vectors++;
      if (bus.if_rdata !== 16'h0 || bus.ld_rdata !== 16'h0) begin
         errors++;
         $display("FAIL reset_rdata got %h/%h exp 0/0", bus.if_rdata, bus.ld_rdata);
      end
      vectors++;
      if ({bus.if_gnt, bus.ld_gnt, bus.mem_en, bus.mem_we} !== 4'b0) begin
         errors++;
         $display("FAIL reset_grant got %b exp 0000", {bus.if_gnt, bus.ld_gnt, bus.mem_en, bus.mem_we});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fetch();
      for (int i = 0; i < 3; i++) begin
         bus.if_req = 1'b1;
         bus.if_addr = 16'(i);
         #3;
         vectors++;
         if (bus.if_gnt !== 1'b1 || bus.ld_gnt !== 1'b0) begin
            errors++;
            $display("FAIL fetch_gnt i=%0d got %b%b exp 10", i, bus.if_gnt, bus.ld_gnt);
         end
         vectors++;
         if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 14'(i)) begin
            errors++;
            $display("FAIL fetch_mem i=%0d got en%b we%b a%h exp en1 we0 a%h", i, bus.mem_en, bus.mem_we, bus.mem_addr, 14'(i));
         end
         push_if(ref_mem[i]);
         tick();
      end
      idle();
      #3;
      vectors++;
      if (bus.mem_en !== 1'b0 || bus.mem_addr !== 14'h0 || bus.mem_wdata !== 16'h0) begin
         errors++;
         $display("FAIL idle_mem got en%b a%h d%h exp 0", bus.mem_en, bus.mem_addr, bus.mem_wdata);
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_ld_rw();
      bus.ld_req = 1'b1;
      bus.ld_we = 1'b1;
      bus.ld_addr = 16'h0010;
      bus.ld_wdata = 16'hBEEF;
      #3;
      vectors++;
      if (bus.ld_gnt !== 1'b1 || bus.if_gnt !== 1'b0 || bus.mem_we !== 1'b1) begin
         errors++;
         $display("FAIL ld_write_gnt got ld%b if%b we%b exp 1 0 1", bus.ld_gnt, bus.if_gnt, bus.mem_we);
      end
      vectors++;
      if (bus.mem_addr !== 14'h0010 || bus.mem_wdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL ld_write_bus got a%h d%h exp a0010 dbeef", bus.mem_addr, bus.mem_wdata);
      end
      ref_mem[16] = 16'hBEEF;
      tick();
      bus.ld_we = 1'b0;
      #3;
      vectors++;
      if (bus.ld_gnt !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 14'h0010) begin
         errors++;
         $display("FAIL ld_read_gnt got gnt%b we%b a%h exp 1 0 0010", bus.ld_gnt, bus.mem_we, bus.mem_addr);
      end
      push_ld(ref_mem[16]);
      tick();
      idle();
      for (int i = 0; i < 3; i++) tick();
      #3;
      vectors++;
      if (bus.if_rdata !== last_if || bus.ld_rdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL rdata_hold got if%h ld%h exp if%h ldbeef", bus.if_rdata, bus.ld_rdata, last_if);
      end
   endtask

   task automatic test_starve();
      logic [19:0] lr_pat = 20'b11111_11111_1110_11111_0;
      logic [19:0] lg_pat = 20'b00001_00001_0000_00001_0;
      logic [15:0] fa = 16'h0020;
      logic        lg;
      for (int k = 0; k < 20; k++) begin
         lg = lg_pat[19-k];
         bus.if_req = 1'b1;
         bus.if_addr = fa;
         bus.ld_req = lr_pat[19-k];
         bus.ld_we = 1'b0;
         bus.ld_addr = 16'h0010;
         #3;
         vectors++;
         if (bus.ld_gnt !== lg || bus.if_gnt !== ~lg) begin
            errors++;
            $display("FAIL starve k=%0d got ld%b if%b exp ld%b if%b", k, bus.ld_gnt, bus.if_gnt, lg, ~lg);
         end
         if (lg) push_ld(ref_mem[16]);
         else begin
            push_if(ref_mem[fa[13:0]]);
            fa = fa + 16'd1;
         end
         tick();
      end
      idle();
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_lock();
      bus.if_req = 1'b1;
      bus.if_addr = 16'h0003;
      #3;
      vectors++;
      if (bus.if_gnt !== 1'b1) begin
         errors++;
         $display("FAIL lock_pre_gnt got %b exp 1", bus.if_gnt);
      end
      push_if(ref_mem[3]);
      tick();
      bus.ld_lock = 1'b1;
      bus.if_addr = 16'h0004;
      for (int i = 0; i < 2; i++) begin
         #3;
         vectors++;
         if (bus.if_gnt !== 1'b0 || bus.mem_en !== 1'b0 || bus.ld_gnt !== 1'b0) begin
            errors++;
            $display("FAIL lock_block i=%0d got if%b en%b ld%b exp 000", i, bus.if_gnt, bus.mem_en, bus.ld_gnt);
         end
         tick();
      end
      bus.ld_req = 1'b1;
      bus.ld_addr = 16'h0003;
      #3;
      vectors++;
      if (bus.ld_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
         errors++;
         $display("FAIL lock_ld got ld%b if%b exp 1 0", bus.ld_gnt, bus.if_gnt);
      end
      push_ld(ref_mem[3]);
      tick();
      bus.ld_lock = 1'b0;
      bus.ld_req = 1'b0;
      #3;
      vectors++;
      if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 14'h0004) begin
         errors++;
         $display("FAIL unlock_fetch got gnt%b a%h exp 1 0004", bus.if_gnt, bus.mem_addr);
      end
      push_if(ref_mem[4]);
      tick();
      idle();
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_wrap();
      bus.ld_req = 1'b1;
      bus.ld_we = 1'b1;
      bus.ld_addr = 16'hC005;
      bus.ld_wdata = 16'h5A5A;
      #3;
      vectors++;
      if (bus.mem_addr !== 14'h0005 || bus.mem_we !== 1'b1) begin
         errors++;
         $display("FAIL wrap_write got a%h we%b exp 0005 1", bus.mem_addr, bus.mem_we);
      end
      ref_mem[5] = 16'h5A5A;
      tick();
      idle();
      bus.if_req = 1'b1;
      bus.if_addr = 16'h0005;
      #3;
      vectors++;
      if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 14'h0005) begin
         errors++;
         $display("FAIL wrap_fetch got gnt%b a%h exp 1 0005", bus.if_gnt, bus.mem_addr);
      end
      push_if(ref_mem[5]);
      tick();
      bus.if_addr = 16'hFFFF;
      #3;
      vectors++;
      if (bus.mem_addr !== 14'h3FFF) begin
         errors++;
         $display("FAIL wrap_top got a%h exp 3fff", bus.mem_addr);
      end
      push_if(ref_mem[16383]);
      tick();
      idle();
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_reset_midflight();
      bus.if_req = 1'b1;
      bus.if_addr = 16'h0007;
      #3;
      vectors++;
      if (bus.if_gnt !== 1'b1) begin
         errors++;
         $display("FAIL midflight_gnt got %b exp 1", bus.if_gnt);
      end
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #3;
      vectors++;
      if ({bus.if_rvalid, bus.ld_rvalid, bus.if_gnt, bus.ld_gnt, bus.mem_en, bus.mem_we} !== 6'b0) begin
         errors++;
         $display("FAIL midflight_ctrl got %b exp 000000", {bus.if_rvalid, bus.ld_rvalid, bus.if_gnt, bus.ld_gnt, bus.mem_en, bus.mem_we});
      end
      vectors++;
      if (bus.if_rdata !== 16'h0 || bus.ld_rdata !== 16'h0 || bus.mem_addr !== 14'h0 || bus.mem_wdata !== 16'h0) begin
         errors++;
         $display("FAIL midflight_data got %h %h %h %h exp 0", bus.if_rdata, bus.ld_rdata, bus.mem_addr, bus.mem_wdata);
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) ref_mem[i] = init_val(14'(i));
      last_if = '0;
      idle();
      test_reset();
      test_fetch();
      test_ld_rw();
      test_starve();
      test_lock();
      test_wrap();
      test_reset_midflight();
      vectors++;
      if (if_q.size() != 0 || ld_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d/%0d pending exp 0/0", if_q.size(), ld_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
